acf_period_detector: RTL and testbench

//  Parametrised time-domain autocorrelation period detector, successor to the FFT-based AutoCorr path.

---
 rtl/acf_period_detector_pkg.sv | 19 +
 rtl/acf_period_detector_if.sv | 34 +++
 rtl/acf_period_detector_mac.sv | 31 +++
 rtl/acf_period_detector.sv | 215 +++++++++++++++++++++
 tb/tb_acf_period_detector.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/acf_period_detector_pkg.sv
// Shared state encoding and width helpers for the autocorrelation period detector.
package acf_period_detector_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      COMPUTE,
      PEAK
   } state_t;

   function automatic int unsigned acc_width(input int unsigned data_width, input int unsigned window);
      return 2 * data_width + $clog2(window);
   endfunction

   function automatic int unsigned lag_width(input int unsigned max_lag);
      return $clog2(max_lag + 1);
   endfunction

endpackage

// File: rtl/acf_period_detector_if.sv
// Control, sample stream and result bundle of the autocorrelation period detector.
interface acf_period_detector_if #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned WINDOW     = 1024,
   parameter int unsigned MAX_LAG    = 511
);
   import acf_period_detector_pkg::*;

   localparam int unsigned ACC_W    = acc_width(DATA_WIDTH, WINDOW);
   localparam int unsigned PERIOD_W = lag_width(MAX_LAG);

   logic                         en;
   logic                         start;
   logic                         continuous;
   logic                         sample_valid;
   logic signed [DATA_WIDTH-1:0] sample_in;
   logic                         busy;
   logic                         result_valid;
   logic [PERIOD_W-1:0]          period;
   logic signed [ACC_W-1:0]      peak_val;
   logic                         stable;
   logic                         overrun;

   modport master (
      output en, start, continuous, sample_valid, sample_in,
      input  busy, result_valid, period, peak_val, stable, overrun
   );

   modport slave (
      input  en, start, continuous, sample_valid, sample_in,
      output busy, result_valid, period, peak_val, stable, overrun
   );

endinterface

// File: rtl/acf_period_detector_mac.sv
// Signed multiply-accumulate lane; fed from the registered sample RAM reads, so a product
// issued as a read address lands in the accumulator two cycles later.
module acf_period_detector_mac #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned ACC_W      = 34
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         valid_in,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [ACC_W-1:0]      acc
);
   localparam int unsigned PROD_W = 2 * DATA_WIDTH;

   logic signed [PROD_W-1:0] prod;

   assign prod = PROD_W'(a) * PROD_W'(b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (valid_in) begin
         acc <= acc + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/acf_period_detector.sv
// Time-domain autocorrelation period detector: buffers a frame, computes R[k] lag by lag, reports the peak lag.
// Optional feature: define ACF_SMOOTH_EN to report the rounded mean of the last 4 stable detections as period.
module acf_period_detector
   import acf_period_detector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 12,
   parameter int unsigned WINDOW       = 1024,
   parameter int unsigned MIN_LAG      = 2,
   parameter int unsigned MAX_LAG      = 511,
   parameter int unsigned STABLE_SHIFT = 1
) (
   input logic                  clk,
   input logic                  rst,
   acf_period_detector_if.slave bus
);
   localparam int unsigned ACC_W = acc_width(DATA_WIDTH, WINDOW);
   localparam int unsigned PW    = lag_width(MAX_LAG);
   localparam int unsigned AW    = $clog2(WINDOW);
   localparam int unsigned CW    = AW + 1;
   localparam logic signed [ACC_W-1:0] ACC_MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

   state_t                       state;
   logic [AW-1:0]                wr_ptr;
   logic [PW-1:0]                lag;
   logic [PW-1:0]                best_lag;
   logic [CW-1:0]                cnt;
   logic [CW-1:0]                lag_len;
   logic                         issue;
   logic                         lag_done;
   logic                         rd_valid;
   logic                         mac_clear;
   logic                         stable_now;
   logic signed [DATA_WIDTH-1:0] ram [WINDOW];
   logic signed [DATA_WIDTH-1:0] rd_a;
   logic signed [DATA_WIDTH-1:0] rd_b;
   logic signed [ACC_W-1:0]      mac_acc;
   logic signed [ACC_W-1:0]      energy;
   logic signed [ACC_W-1:0]      best;
   logic [PW-1:0]                period_q;
   logic [PW-1:0]                period_next;
   logic signed [ACC_W-1:0]      peak_q;
   logic                         result_valid_q;
   logic                         stable_q;
   logic                         overrun_q;

   // Each lag issues WINDOW-k reads, then two drain cycles; R[k] is final on the last one.
   assign lag_len    = CW'(WINDOW) - CW'(lag);
   assign issue      = (state == COMPUTE) && (cnt < lag_len);
   assign lag_done   = (state == COMPUTE) && (cnt == lag_len + CW'(1));
   assign mac_clear  = (state != COMPUTE) || lag_done;
   assign stable_now = (energy != '0) && (best >= (energy >>> STABLE_SHIFT));

   always_ff @(posedge clk) begin
      if (bus.en && (state == COLLECT) && bus.sample_valid) begin
         ram[wr_ptr] <= bus.sample_in;
      end
      rd_a <= ram[cnt[AW-1:0]];
      rd_b <= ram[cnt[AW-1:0] + AW'(lag)];
   end

   acf_period_detector_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clear    (mac_clear),
      .valid_in (rd_valid),
      .a        (rd_a),
      .b        (rd_b),
      .acc      (mac_acc)
   );

`ifdef ACF_SMOOTH_EN
   localparam int unsigned SW = PW + 2;

   logic [PW-1:0] hist     [4];
   logic [PW-1:0] hist_new [4];
   logic [2:0]    hist_cnt;
   logic [2:0]    cnt_new;
   logic [SW-1:0] hist_sum;

   // Unstable frames leave the history untouched; the mean covers only the entries present.
   always_comb begin
      hist_new = hist;
      cnt_new  = hist_cnt;
      if (stable_now) begin
         hist_new[0] = best_lag;
         for (int unsigned i = 1; i < 4; i++) begin
            hist_new[i] = hist[i-1];
         end
         cnt_new = (hist_cnt == 3'd4) ? 3'd4 : hist_cnt + 3'd1;
      end
      hist_sum = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (3'(i) < cnt_new) begin
            hist_sum = hist_sum + SW'(hist_new[i]);
         end
      end
      case (cnt_new)
         3'd0:    period_next = best_lag;
         3'd1:    period_next = hist_new[0];
         3'd2:    period_next = PW'((hist_sum + SW'(1)) >> 1);
         3'd3:    period_next = PW'((hist_sum + SW'(1)) / SW'(3));
         default: period_next = PW'((hist_sum + SW'(2)) >> 2);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist     <= '{default: '0};
         hist_cnt <= '0;
      end else if (bus.en && (state == PEAK)) begin
         hist     <= hist_new;
         hist_cnt <= cnt_new;
      end
   end
`else
   assign period_next = best_lag;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         lag            <= '0;
         cnt            <= '0;
         rd_valid       <= 1'b0;
         energy         <= '0;
         best           <= '0;
         best_lag       <= '0;
         period_q       <= '0;
         peak_q         <= '0;
         stable_q       <= 1'b0;
         result_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         rd_valid       <= issue;
         if (!bus.en) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (bus.start || bus.continuous) begin
                     state     <= COLLECT;
                     wr_ptr    <= '0;
                     overrun_q <= 1'b0;
                  end
               end
               COLLECT: begin
                  if (bus.sample_valid) begin
                     wr_ptr <= wr_ptr + AW'(1);
                     if (wr_ptr == AW'(WINDOW - 1)) begin
                        state    <= COMPUTE;
                        cnt      <= '0;
                        lag      <= '0;
                        best     <= ACC_MOST_NEG;
                        best_lag <= PW'(MIN_LAG);
                     end
                  end
               end
               COMPUTE: begin
                  if (bus.sample_valid) begin
                     overrun_q <= 1'b1;
                  end
                  if (lag_done) begin
                     cnt <= '0;
                     if (lag == '0) begin
                        energy <= mac_acc;
                        lag    <= PW'(MIN_LAG);
                     end else begin
                        if (mac_acc > best) begin
                           best     <= mac_acc;
                           best_lag <= lag;
                        end
                        if (lag == PW'(MAX_LAG)) begin
                           state <= PEAK;
                        end else begin
                           lag <= lag + PW'(1);
                        end
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               PEAK: begin
                  if (bus.sample_valid) begin
                     overrun_q <= 1'b1;
                  end
                  period_q       <= period_next;
                  peak_q         <= best;
                  stable_q       <= stable_now;
                  result_valid_q <= 1'b1;
                  if (bus.continuous) begin
                     state     <= COLLECT;
                     wr_ptr    <= '0;
                     overrun_q <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            endcase
         end
      end
   end

   assign bus.busy         = (state != IDLE);
   assign bus.result_valid = result_valid_q;
   assign bus.period       = period_q;
   assign bus.peak_val     = peak_q;
   assign bus.stable       = stable_q;
   assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_acf_period_detector.sv
// Directed self-checking bench for acf_period_detector on a reduced 128-sample window.
module tb_acf_period_detector;
   localparam int unsigned DW    = 12;
   localparam int unsigned WIN   = 128;
   localparam int unsigned MINL  = 2;
   localparam int unsigned MAXL  = 63;
   localparam int unsigned SH    = 1;
   localparam int unsigned ACC_W = 2 * DW + $clog2(WIN);
   localparam int unsigned PER_W = $clog2(MAXL + 1);
   localparam logic signed [DW-1:0] POS = 12'sd1000;
   localparam logic signed [DW-1:0] NEG = -12'sd1000;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic signed [DW-1:0] frame [WIN];

   acf_period_detector_if #(.DATA_WIDTH(DW), .WINDOW(WIN), .MAX_LAG(MAXL)) bus ();

   acf_period_detector #(
      .DATA_WIDTH   (DW),
      .WINDOW       (WIN),
      .MIN_LAG      (MINL),
      .MAX_LAG      (MAXL),
      .STABLE_SHIFT (SH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed_frame();
      for (int i = 0; i < int'(WIN); i++) begin
         bus.sample_valid = 1'b1;
         bus.sample_in    = frame[i];
         tick();
         bus.sample_valid = 1'b0;
         tick();
      end
   endtask

   task automatic start_and_feed();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      feed_frame();
   endtask

   task automatic wait_result(output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 10000 && !seen; c++) begin
         tick();
         if (bus.result_valid === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic fill_square();
      for (int i = 0; i < int'(WIN); i++) frame[i] = ((i % 8) < 4) ? POS : NEG;
   endtask

   task automatic fill_alternating();
      for (int i = 0; i < int'(WIN); i++) frame[i] = ((i % 2) == 0) ? POS : NEG;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b expected 0", bus.result_valid); end
      checks++; if (bus.period !== PER_W'(0)) begin errors++; $display("FAIL reset_period: got %0d expected 0", bus.period); end
      checks++; if (bus.peak_val !== ACC_W'(0)) begin errors++; $display("FAIL reset_peak_val: got %0d expected 0", bus.peak_val); end
      checks++; if (bus.stable !== 1'b0) begin errors++; $display("FAIL reset_stable: got %b expected 0", bus.stable); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
      rst    = 1'b0;
      bus.en = 1'b1;
      tick();
   endtask

   task automatic test_square();
      bit seen;
      fill_square();
      start_and_feed();
      wait_result(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL square_timeout: result_valid got 0 expected 1"); end
      checks++; if (bus.period !== PER_W'(8)) begin errors++; $display("FAIL square_period: got %0d expected 8", bus.period); end
      checks++; if (bus.peak_val !== ACC_W'(120000000)) begin errors++; $display("FAIL square_peak_val: got %0d expected 120000000", bus.peak_val); end
      checks++; if (bus.stable !== 1'b1) begin errors++; $display("FAIL square_stable: got %b expected 1", bus.stable); end
      tick();
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL square_pulse_width: result_valid got %b expected 0", bus.result_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL square_busy_after: got %b expected 0", bus.busy); end
   endtask

   task automatic test_zero_frame();
      bit seen;
      for (int i = 0; i < int'(WIN); i++) frame[i] = '0;
      start_and_feed();
      wait_result(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL zero_timeout: result_valid got 0 expected 1"); end
      checks++; if (bus.period !== PER_W'(MINL)) begin errors++; $display("FAIL zero_period: got %0d expected %0d", bus.period, MINL); end
      checks++; if (bus.peak_val !== ACC_W'(0)) begin errors++; $display("FAIL zero_peak_val: got %0d expected 0", bus.peak_val); end
      checks++; if (bus.stable !== 1'b0) begin errors++; $display("FAIL zero_stable: got %b expected 0", bus.stable); end
   endtask

   // Sparse impulses: lone sample, exact stability threshold, and a six-way tie on R[k].
   task automatic test_impulses();
      bit seen;
      logic [PER_W-1:0]        ep;
      logic signed [ACC_W-1:0] epk;
      logic                    est;
      for (int sc = 0; sc < 3; sc++) begin
         for (int i = 0; i < int'(WIN); i++) frame[i] = '0;
         frame[0] = POS;
         case (sc)
            0: begin ep = PER_W'(2); epk = ACC_W'(0); est = 1'b0; end
            1: begin frame[5] = POS; ep = PER_W'(5); epk = ACC_W'(1000000); est = 1'b1; end
            default: begin
               frame[3] = POS; frame[10] = POS; frame[16] = POS;
               ep = PER_W'(3); epk = ACC_W'(1000000); est = 1'b0;
            end
         endcase
         start_and_feed();
         wait_result(seen);
         checks++; if (seen !== 1'b1) begin errors++; $display("FAIL impulse%0d_timeout: result_valid got 0 expected 1", sc); end
         checks++; if (bus.period !== ep) begin errors++; $display("FAIL impulse%0d_period: got %0d expected %0d", sc, bus.period, ep); end
         checks++; if (bus.peak_val !== epk) begin errors++; $display("FAIL impulse%0d_peak_val: got %0d expected %0d", sc, bus.peak_val, epk); end
         checks++; if (bus.stable !== est) begin errors++; $display("FAIL impulse%0d_stable: got %b expected %b", sc, bus.stable, est); end
      end
   endtask

   task automatic test_min_lag_alternating();
      bit seen;
      fill_alternating();
      start_and_feed();
      wait_result(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL alt_timeout: result_valid got 0 expected 1"); end
      checks++; if (bus.period !== PER_W'(2)) begin errors++; $display("FAIL alt_period: got %0d expected 2", bus.period); end
      checks++; if (bus.peak_val !== ACC_W'(126000000)) begin errors++; $display("FAIL alt_peak_val: got %0d expected 126000000", bus.peak_val); end
      checks++; if (bus.stable !== 1'b1) begin errors++; $display("FAIL alt_stable: got %b expected 1", bus.stable); end
   endtask

   task automatic test_overrun_en_low();
      bit seen;
      fill_square();
      start_and_feed();
      repeat (20) tick();
      bus.sample_valid = 1'b1;
      bus.sample_in    = 12'sd2047;
      tick();
      bus.sample_valid = 1'b0;
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
      wait_result(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL overrun_timeout: result_valid got 0 expected 1"); end
      checks++; if (bus.period !== PER_W'(8)) begin errors++; $display("FAIL overrun_period: got %0d expected 8", bus.period); end
      checks++; if (bus.peak_val !== ACC_W'(120000000)) begin errors++; $display("FAIL overrun_peak_val: got %0d expected 120000000", bus.peak_val); end
      repeat (5) tick();
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun); end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared: got %b expected 0", bus.overrun); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL collect_busy: got %b expected 1", bus.busy); end
      for (int i = 0; i < 30; i++) begin
         bus.sample_valid = 1'b1;
         bus.sample_in    = NEG;
         tick();
         bus.sample_valid = 1'b0;
      end
      bus.en = 1'b0;
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL enlow_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL enlow_no_pulse: got %b expected 0", bus.result_valid); end
      checks++; if (bus.period !== PER_W'(8)) begin errors++; $display("FAIL enlow_period_hold: got %0d expected 8", bus.period); end
      checks++; if (bus.peak_val !== ACC_W'(120000000)) begin errors++; $display("FAIL enlow_peak_hold: got %0d expected 120000000", bus.peak_val); end
      bus.en = 1'b1;
      repeat (3) tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL enlow_stays_idle: got %b expected 0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      bit seen;
      fill_square();
      bus.continuous = 1'b1;
      tick();
      feed_frame();
      wait_result(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout: result_valid got 0 expected 1"); end
      checks++; if (bus.period !== PER_W'(8)) begin errors++; $display("FAIL b2b_first_period: got %0d expected 8", bus.period); end
      tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_recollect_busy: got %b expected 1", bus.busy); end
      fill_alternating();
      feed_frame();
      wait_result(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_second_timeout: result_valid got 0 expected 1"); end
      checks++; if (bus.period !== PER_W'(2)) begin errors++; $display("FAIL b2b_second_period: got %0d expected 2", bus.period); end
      checks++; if (bus.peak_val !== ACC_W'(126000000)) begin errors++; $display("FAIL b2b_second_peak_val: got %0d expected 126000000", bus.peak_val); end
      bus.continuous = 1'b0;
      bus.en         = 1'b0;
      tick();
      bus.en = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_rst_mid_compute();
      fill_square();
      start_and_feed();
      repeat (40) tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b expected 1", bus.busy); end
      rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.period !== PER_W'(0)) begin errors++; $display("FAIL rstmid_period: got %0d expected 0", bus.period); end
      checks++; if (bus.peak_val !== ACC_W'(0)) begin errors++; $display("FAIL rstmid_peak_val: got %0d expected 0", bus.peak_val); end
      checks++; if (bus.stable !== 1'b0) begin errors++; $display("FAIL rstmid_stable: got %b expected 0", bus.stable); end
      tick();
      rst = 1'b0;
      repeat (3) tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_after: got %b expected 0", bus.busy); end
   endtask

   initial begin
      rst              = 1'b1;
      bus.en           = 1'b0;
      bus.start        = 1'b0;
      bus.continuous   = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_in    = '0;
      test_reset();
      test_square();
      test_zero_frame();
      test_impulses();
      test_min_lag_alternating();
      test_overrun_en_low();
      test_back_to_back();
      test_rst_mid_compute();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
